lab10_1_sec_timer: RTL and testbench

//  mm:ss BCD stopwatch stage sitting directly downstream of the 1 Hz divider.

---
 rtl/lab10_1_sec_timer.sv | 209 ++++++++++++++++++++
 tb/tb_lab10_1_sec_timer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab10_1_sec_timer.sv
// -----------------------------------------------------------------------------
// lab10_1_sec_timer
//
// mm:ss BCD stopwatch that sits directly after the 1 Hz divider. The divider's
// square wave is synchronised into the clk domain, and each rising edge becomes
// a one-cycle tick. The tick advances four BCD digits under start/stop/clear
// control. The digits feed the 7-segment scan stage.
//
// Parameters
//   MAX_MIN      terminal minute value, 1..99
//   WRAP         1: MAX_MIN:59 -> 00:00 with an ovf pulse, keeps running
//                0: the tick that reaches MAX_MIN:59 enters DONE, count holds
//   SYNC_STAGES  synchroniser depth on sec_in, 2..3
//
// Ports
//   clk         in   global clock, posedge
//   rst         in   synchronous reset, active high
//   sec_in      in   1 Hz square wave, asynchronous to clk
//   start_stop  in   1-cycle pulse, toggles run/pause
//   clear       in   1-cycle pulse, zeroes the count and returns to IDLE
//   lap         in   1-cycle pulse, freezes/unfreezes the display (lap build)
//   min1, min0  out  BCD minutes (tens, units)
//   sec1, sec0  out  BCD seconds (tens, units)
//   running     out  high while the FSM is in RUN (registered)
//   ovf         out  1-cycle pulse on wrap (always 0 when WRAP = 0)
//
// Build option
//   LAB10_LAP_EN  adds the lap port and the display snapshot registers.
//                 Without it, the outputs are the live count.
// -----------------------------------------------------------------------------
module lab10_1_sec_timer #(
    parameter int MAX_MIN     = 59,
    parameter int WRAP        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_in,
    input  logic       start_stop,
    input  logic       clear,
`ifdef LAB10_LAP_EN
    input  logic       lap,
`endif
    output logic [3:0] min1,
    output logic [3:0] min0,
    output logic [3:0] sec1,
    output logic [3:0] sec0,
    output logic       running,
    output logic       ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [3:0]  MAX_MIN1 = 4'(MAX_MIN / 10);
    localparam logic [3:0]  MAX_MIN0 = 4'(MAX_MIN % 10);
    // Count packed as {min1, min0, sec1, sec0}.
    localparam logic [15:0] TERM     = {MAX_MIN1, MAX_MIN0, 4'd5, 4'd9};

    // One-second BCD increment with the digit-wise carry chain.
    // The caller handles the terminal value, so min1 never exceeds 9.
    function automatic logic [15:0] bcd_inc(input logic [15:0] c);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = c;
        if (s0 == 4'd9) begin
            s0 = 4'd0;
            if (s1 == 4'd5) begin
                s1 = 4'd0;
                if (m0 == 4'd9) begin
                    m0 = 4'd0;
                    m1 = m1 + 4'd1;
                end else begin
                    m0 = m0 + 4'd1;
                end
            end else begin
                s1 = s1 + 4'd1;
            end
        end else begin
            s0 = s0 + 4'd1;
        end
        return {m1, m0, s1, s0};
    endfunction

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   tick;
    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [15:0]            cnt_inc;
    logic                   ovf_q, ovf_d;
    logic                   running_q;

    // The synchroniser's last stage, delayed by one flop, marks the rising
    // edge. Falling edges give sync_last = 0 and so produce no tick.
    assign tick    = sync_q[SYNC_STAGES-1] & ~edge_q;
    assign cnt_inc = bcd_inc(cnt_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        if (clear) begin
            // clear also beats a coincident tick, so there is no increment.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (tick) begin
                        if (cnt_q == TERM) begin
                            if (WRAP != 0) begin
                                cnt_d = '0;
                                ovf_d = 1'b1;
                            end else begin
                                state_d = S_DONE;
                            end
                        end else begin
                            cnt_d = cnt_inc;
                            if ((WRAP == 0) && (cnt_inc == TERM)) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                    // The pause takes priority over the state change, but a
                    // coincident tick's increment is still applied.
                    if (start_stop) begin
                        state_d = S_PAUSE;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            edge_q    <= 1'b0;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], sec_in};
            edge_q    <= sync_q[SYNC_STAGES-1];
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == S_RUN);
        end
    end

`ifdef LAB10_LAP_EN
    logic        lap_hold_q, lap_hold_d;
    logic [15:0] snap_q, snap_d;

    // The snapshot is taken only on the entry into hold. The live count keeps
    // running underneath it.
    always_comb begin
        lap_hold_d = lap_hold_q;
        snap_d     = snap_q;
        if (clear) begin
            lap_hold_d = 1'b0;
        end else if (lap && ((state_q == S_RUN) || (state_q == S_PAUSE))) begin
            lap_hold_d = ~lap_hold_q;
            if (!lap_hold_q) begin
                snap_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lap_hold_q <= 1'b0;
            snap_q     <= '0;
        end else begin
            lap_hold_q <= lap_hold_d;
            snap_q     <= snap_d;
        end
    end

    assign {min1, min0, sec1, sec0} = lap_hold_q ? snap_q : cnt_q;
`else
    assign {min1, min0, sec1, sec0} = cnt_q;
`endif

    assign running = running_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_lab10_1_sec_timer.sv
`timescale 1ns/1ps
module tb_lab10_1_sec_timer;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst        = 1'b1;
    logic sec_in     = 1'b0;
    logic start_stop = 1'b0;
    logic clear      = 1'b0;
`ifdef LAB10_LAP_EN
    logic lap        = 1'b0;
`endif

    logic [3:0] m1_m, m0_m, s1_m, s0_m;
    logic       run_m, ovf_m;
    logic [3:0] m1_w, m0_w, s1_w, s0_w;
    logic       run_w, ovf_w;
    logic [3:0] m1_h, m0_h, s1_h, s0_h;
    logic       run_h, ovf_h;

    wire [15:0] disp_m = {m1_m, m0_m, s1_m, s0_m};
    wire [15:0] disp_w = {m1_w, m0_w, s1_w, s0_w};
    wire [15:0] disp_h = {m1_h, m0_h, s1_h, s0_h};

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    // Main DUT: default configuration (59 minutes, wrap, 2 sync stages).
    lab10_1_sec_timer u_main (
        .clk(clk), .rst(rst), .sec_in(sec_in), .start_stop(start_stop), .clear(clear),
`ifdef LAB10_LAP_EN
        .lap(lap),
`endif
        .min1(m1_m), .min0(m0_m), .sec1(s1_m), .sec0(s0_m), .running(run_m), .ovf(ovf_m)
    );

    // Short 1-minute wrapping counter.
    lab10_1_sec_timer #(.MAX_MIN(1), .WRAP(1), .SYNC_STAGES(SYNC)) u_wrap (
        .clk(clk), .rst(rst), .sec_in(sec_in), .start_stop(start_stop), .clear(clear),
`ifdef LAB10_LAP_EN
        .lap(lap),
`endif
        .min1(m1_w), .min0(m0_w), .sec1(s1_w), .sec0(s0_w), .running(run_w), .ovf(ovf_w)
    );

    // Short 1-minute counter that stops at its terminal value.
    lab10_1_sec_timer #(.MAX_MIN(1), .WRAP(0), .SYNC_STAGES(SYNC)) u_hold (
        .clk(clk), .rst(rst), .sec_in(sec_in), .start_stop(start_stop), .clear(clear),
`ifdef LAB10_LAP_EN
        .lap(lap),
`endif
        .min1(m1_h), .min0(m0_h), .sec1(s1_h), .sec0(s0_h), .running(run_h), .ovf(ovf_h)
    );

    // Reference model: elapsed seconds to {min1, min0, sec1, sec0}.
    function automatic logic [15:0] to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    task automatic pulse_ss();
        @(posedge clk); #1 start_stop = 1'b1;
        @(posedge clk); #1 start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    // Drives one sec_in period, made of 5 cycles high and 5 cycles low.
    // sec_in rises between two clock edges. lat is the number of clk edges
    // after the rise until the main display changes: one edge for each
    // synchroniser flop, one for the edge-detect/count register. In other
    // words, the new value is visible in cycle SYNC+2 if the cycle in which
    // sec_in rises is numbered 1. lat is -1 when nothing changes within the
    // 10-cycle window. The task also counts the ovf cycles of the two short
    // counters.
    task automatic sec_edge(output int lat, output int wrap_ovf, output int hold_ovf);
        logic [15:0] prev;
        @(posedge clk); #2;
        sec_in   = 1'b1;
        prev     = disp_m;
        lat      = -1;
        wrap_ovf = 0;
        hold_ovf = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (lat < 0 && disp_m !== prev) lat = k;
            if (ovf_w === 1'b1) wrap_ovf++;
            if (ovf_h === 1'b1) hold_ovf++;
            if (k == 5) sec_in = 1'b0;
        end
    endtask

    // Raises sec_in and returns in the cycle in which the resulting tick is
    // high, so that a control pulse can be driven to coincide with it.
    task automatic rise_to_tick();
        @(posedge clk); #2 sec_in = 1'b1;
        repeat (SYNC) @(posedge clk);
        #1;
    endtask

    task automatic finish_period();
        repeat (3) @(posedge clk);
        #1 sec_in = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1 sec_in = 1'b1;
        @(posedge clk); #1 sec_in = 1'b0;
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL reset_digits_main: got %h want 0000", disp_m); end
        total++; if (disp_w !== 16'h0000) begin bad++; $display("FAIL reset_digits_wrap: got %h want 0000", disp_w); end
        total++; if (disp_h !== 16'h0000) begin bad++; $display("FAIL reset_digits_hold: got %h want 0000", disp_h); end
        total++; if (run_m !== 1'b0) begin bad++; $display("FAIL reset_running: got %b want 0", run_m); end
        total++; if (ovf_m !== 1'b0 || ovf_w !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b%b want 00", ovf_m, ovf_w); end
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL reset_idle_digits: got %h want 0000", disp_m); end
        total++; if (run_m !== 1'b0) begin bad++; $display("FAIL reset_idle_running: got %b want 0", run_m); end
    endtask

    task automatic test_count();
        int lat, ow, oh;
        logic [15:0] exp;
        pulse_ss();
        total++; if (run_m !== 1'b1) begin bad++; $display("FAIL count_running: got %b want 1", run_m); end
        for (int i = 1; i <= 75; i++) begin
            exp_q.push_back(to_bcd(i));
            sec_edge(lat, ow, oh);
            exp = exp_q.pop_front();
            total++; if (disp_m !== exp) begin bad++; $display("FAIL count_digits[%0d]: got %h want %h", i, disp_m, exp); end
            total++; if (lat != SYNC + 1) begin bad++; $display("FAIL count_latency[%0d]: got %0d want %0d", i, lat, SYNC + 1); end
        end
        total++; if (disp_m !== 16'h0115) begin bad++; $display("FAIL count_final: got %h want 0115", disp_m); end
        total++; if (ovf_m !== 1'b0) begin bad++; $display("FAIL count_ovf: got %b want 0", ovf_m); end
    endtask

    task automatic test_pause_tick();
        int lat, ow, oh;
        logic [15:0] exp;
        pulse_clear();
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL pause_clear: got %h want 0000", disp_m); end
        pulse_ss();
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(to_bcd(i));
            sec_edge(lat, ow, oh);
            exp = exp_q.pop_front();
            total++; if (disp_m !== exp) begin bad++; $display("FAIL pause_pre[%0d]: got %h want %h", i, disp_m, exp); end
        end
        rise_to_tick();
        start_stop = 1'b1;
        @(posedge clk); #1 start_stop = 1'b0;
        total++; if (disp_m !== 16'h0010) begin bad++; $display("FAIL pause_coincident_digits: got %h want 0010", disp_m); end
        total++; if (run_m !== 1'b0) begin bad++; $display("FAIL pause_coincident_running: got %b want 0", run_m); end
        finish_period();
        for (int i = 0; i < 5; i++) begin
            sec_edge(lat, ow, oh);
            total++; if (lat != -1) begin bad++; $display("FAIL pause_ignores_tick[%0d]: got change after %0d want none", i, lat); end
        end
        total++; if (disp_m !== 16'h0010) begin bad++; $display("FAIL pause_hold: got %h want 0010", disp_m); end
    endtask

    task automatic test_clear_rst();
        int lat, ow, oh;
        logic [15:0] exp;
        pulse_clear();
        pulse_ss();
        for (int i = 1; i <= 30; i++) begin
            exp_q.push_back(to_bcd(i));
            sec_edge(lat, ow, oh);
            exp = exp_q.pop_front();
            total++; if (disp_m !== exp) begin bad++; $display("FAIL clear_pre[%0d]: got %h want %h", i, disp_m, exp); end
        end
        rise_to_tick();
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL clear_coincident_digits: got %h want 0000", disp_m); end
        total++; if (run_m !== 1'b0) begin bad++; $display("FAIL clear_coincident_running: got %b want 0", run_m); end
        finish_period();
        sec_edge(lat, ow, oh);
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL clear_idle_no_count: got %h want 0000", disp_m); end
        pulse_ss();
        for (int i = 1; i <= 42; i++) begin
            exp_q.push_back(to_bcd(i));
            sec_edge(lat, ow, oh);
            exp = exp_q.pop_front();
            total++; if (disp_m !== exp) begin bad++; $display("FAIL rst_pre[%0d]: got %h want %h", i, disp_m, exp); end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL rst_mid_digits: got %h want 0000", disp_m); end
        total++; if (run_m !== 1'b0) begin bad++; $display("FAIL rst_mid_running: got %b want 0", run_m); end
        rst = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_wrap();
        int lat, ow, oh, ow_sum, oh_sum;
        ow_sum = 0;
        oh_sum = 0;
        pulse_clear();
        pulse_ss();
        for (int i = 1; i <= 118; i++) begin
            sec_edge(lat, ow, oh);
            ow_sum += ow;
            oh_sum += oh;
        end
        total++; if (disp_w !== 16'h0158) begin bad++; $display("FAIL wrap_at_0158: got %h want 0158", disp_w); end
        total++; if (disp_h !== 16'h0158) begin bad++; $display("FAIL hold_at_0158: got %h want 0158", disp_h); end
        total++; if (run_w !== 1'b1 || run_h !== 1'b1) begin bad++; $display("FAIL wrap_running_0158: got %b%b want 11", run_w, run_h); end
        total++; if (ow_sum != 0) begin bad++; $display("FAIL wrap_early_ovf: got %0d want 0", ow_sum); end
        sec_edge(lat, ow, oh);
        total++; if (disp_w !== 16'h0159) begin bad++; $display("FAIL wrap_at_0159: got %h want 0159", disp_w); end
        total++; if (disp_h !== 16'h0159) begin bad++; $display("FAIL hold_at_0159: got %h want 0159", disp_h); end
        total++; if (ow != 0) begin bad++; $display("FAIL wrap_ovf_0159: got %0d want 0", ow); end
        sec_edge(lat, ow, oh);
        oh_sum += oh;
        total++; if (disp_w !== 16'h0000) begin bad++; $display("FAIL wrap_to_zero: got %h want 0000", disp_w); end
        total++; if (ow != 1) begin bad++; $display("FAIL wrap_ovf_pulse: got %0d cycles want 1", ow); end
        total++; if (run_w !== 1'b1) begin bad++; $display("FAIL wrap_keeps_running: got %b want 1", run_w); end
        total++; if (disp_h !== 16'h0159) begin bad++; $display("FAIL hold_terminal: got %h want 0159", disp_h); end
        total++; if (run_h !== 1'b0) begin bad++; $display("FAIL hold_done_running: got %b want 0", run_h); end
        total++; if (disp_m !== 16'h0200) begin bad++; $display("FAIL main_at_0200: got %h want 0200", disp_m); end
        pulse_ss();
        total++; if (run_h !== 1'b0) begin bad++; $display("FAIL hold_ignores_ss: got %b want 0", run_h); end
        sec_edge(lat, ow, oh);
        oh_sum += oh;
        total++; if (disp_h !== 16'h0159) begin bad++; $display("FAIL hold_stays: got %h want 0159", disp_h); end
        total++; if (oh_sum != 0) begin bad++; $display("FAIL hold_ovf_tied: got %0d want 0", oh_sum); end
    endtask

`ifdef LAB10_LAP_EN
    task automatic test_lap();
        int lat, ow, oh;
        pulse_clear();
        pulse_ss();
        for (int i = 1; i <= 20; i++) sec_edge(lat, ow, oh);
        total++; if (disp_m !== 16'h0020) begin bad++; $display("FAIL lap_pre: got %h want 0020", disp_m); end
        @(posedge clk); #1 lap = 1'b1;
        @(posedge clk); #1 lap = 1'b0;
        for (int i = 1; i <= 10; i++) sec_edge(lat, ow, oh);
        total++; if (disp_m !== 16'h0020) begin bad++; $display("FAIL lap_frozen: got %h want 0020", disp_m); end
        @(posedge clk); #1 lap = 1'b1;
        @(posedge clk); #1 lap = 1'b0;
        total++; if (disp_m !== 16'h0030) begin bad++; $display("FAIL lap_release: got %h want 0030", disp_m); end
        @(posedge clk); #1 lap = 1'b1;
        @(posedge clk); #1 lap = 1'b0;
        sec_edge(lat, ow, oh);
        total++; if (disp_m !== 16'h0030) begin bad++; $display("FAIL lap_second_hold: got %h want 0030", disp_m); end
        pulse_clear();
        total++; if (disp_m !== 16'h0000) begin bad++; $display("FAIL lap_clear: got %h want 0000", disp_m); end
        pulse_ss();
        sec_edge(lat, ow, oh);
        total++; if (disp_m !== 16'h0001) begin bad++; $display("FAIL lap_clear_releases: got %h want 0001", disp_m); end
    endtask
`endif

    initial begin
        test_reset();
        test_count();
        test_pause_tick();
        test_clear_rst();
        test_wrap();
`ifdef LAB10_LAP_EN
        test_lap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
